// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one combinational lookup ROM between NUM_REQ requesters.
// Round-robin grant in IDLE, one registered ROM read, then a held response
// (valid/ready) owned by the granted requester. One transaction in flight.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   req_valid     per-requester read request
//   req_addr      flattened request addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready     one-hot accept strobe, combinational, asserted in IDLE only
//   rsp_valid     one-hot response valid (granted requester)
//   rsp_data      response data (zero when the address was out of range)
//   rsp_err       response address was >= DEPTH
//   rsp_ready     per-requester response accept
//   rom_address   registered address into the ROM
//   rom_data      combinational data from the ROM
module rom_read_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned DEPTH   = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [ADDR_W-1:0]           rom_address,
    input  logic [DATA_W-1:0]           rom_data
);

    localparam int unsigned GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          NREQ  = int'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [GNT_W-1:0]    r_last_grant;
    logic [GNT_W-1:0]    r_gnt;
    logic [ADDR_W-1:0]   r_rom_address;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic [NUM_REQ-1:0]  r_rsp_valid;

    logic                w_any;
    logic [GNT_W-1:0]    w_gnt;
    int                  w_best;
    int                  w_dist;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_accept;
    logic                w_rsp_done;
    logic                w_oor;

    // Round-robin pick: smallest distance after last_grant wins.
    always_comb begin
        w_any  = 1'b0;
        w_gnt  = '0;
        w_best = NREQ;
        w_dist = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + NREQ - int'(r_last_grant) - 1) % NREQ;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_any  = 1'b1;
                w_best = w_dist;
                w_gnt  = GNT_W'(i);
            end
        end
    end

    // Address of the requester being granted this cycle.
    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt == GNT_W'(i)) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Compare at 32 bits so DEPTH == 2**ADDR_W does not wrap to zero.
    assign w_oor = (32'(r_rom_address) >= 32'(DEPTH));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake strobes; nothing is accepted while in reset.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && !rst) begin
                    req_ready[w_gnt] = 1'b1;
                    w_accept         = 1'b1;
                    w_state_nxt      = ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[r_gnt]) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: address capture, ROM sample, response hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_address <= '0;
            r_gnt         <= '0;
            r_last_grant  <= GNT_W'(NUM_REQ - 1);
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_valid   <= '0;
        end else begin
            if (w_accept) begin
                r_rom_address <= w_sel_addr;
                r_gnt         <= w_gnt;
            end
            if (r_state == ST_READ) begin
                r_rsp_err   <= w_oor;
                r_rsp_data  <= w_oor ? '0 : rom_data;
                r_rsp_valid <= NUM_REQ'(1) << r_gnt;
            end
            if (w_rsp_done) begin
                r_rsp_valid  <= '0;
                r_last_grant <= r_gnt;
            end
        end
    end

    assign rom_address = r_rom_address;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign rsp_valid   = r_rsp_valid;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a behavioural lookup ROM.
module tb_rom_read_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [7:0]  req_addr;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [9:0]  rsp_data;
    logic        rsp_err;
    logic [1:0]  rsp_ready;
    logic [3:0]  rom_address;
    logic [9:0]  rom_data;

    int n_checks;
    int n_errors;

    // Lookup table standing in for rom2; out-of-range entries read as all ones
    // so a missing zeroing of rsp_data is visible.
    function automatic logic [9:0] rom2_f(input logic [3:0] a);
        case (a)
            4'd0: rom2_f = 10'h0A5;
            4'd1: rom2_f = 10'h13C;
            4'd2: rom2_f = 10'h2F0;
            4'd3: rom2_f = 10'h07E;
            4'd4: rom2_f = 10'h311;
            4'd5: rom2_f = 10'h1D2;
            4'd6: rom2_f = 10'h248;
            4'd7: rom2_f = 10'h09B;
            4'd8: rom2_f = 10'h366;
            4'd9: rom2_f = 10'h1F7;
            default: rom2_f = 10'h3FF;
        endcase
    endfunction

    assign rom_data = rom2_f(rom_address);

    rom_read_arbiter #(
        .NUM_REQ (2),
        .ADDR_W  (4),
        .DATA_W  (10),
        .DEPTH   (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rsp_ready   (rsp_ready),
        .rom_address (rom_address),
        .rom_data    (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction starting in IDLE at a falling edge; the owner must
    // have rsp_ready high. Ends at the falling edge after the response is taken.
    task automatic run_txn(input string tag, input logic [1:0] owner, input logic [3:0] addr);
        logic       exp_err;
        logic [9:0] exp_data;
        exp_err  = (addr >= 4'd10);
        exp_data = exp_err ? 10'd0 : rom2_f(addr);
        #1;
        check_eq({tag, ".req_ready"}, 32'(req_ready), 32'(owner));
        @(negedge clk);
        check_eq({tag, ".read_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, ".read_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, ".rom_address"}, 32'(rom_address), 32'(addr));
        @(negedge clk);
        check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(owner));
        check_eq({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp_data));
        check_eq({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
        @(negedge clk);
        check_eq({tag, ".rsp_clear"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req_valid = 2'b11;
        req_addr  = {4'd5, 4'd1};
        rsp_ready = 2'b11;

        // Reset held two cycles with both requests pending.
        @(negedge clk);
        @(negedge clk);
        check_eq("rst.req_ready", 32'(req_ready), 32'd0);
        check_eq("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst.rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst.rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst.rom_address", 32'(rom_address), 32'd0);
        rst = 1'b0;

        // Round robin with both requesting: 0,1,0,1.
        run_txn("rr0", 2'b01, 4'd1);
        run_txn("rr1", 2'b10, 4'd5);
        run_txn("rr2", 2'b01, 4'd1);
        run_txn("rr3", 2'b10, 4'd5);

        // Single read from requester 0.
        req_valid = 2'b01;
        req_addr  = {4'd0, 4'd3};
        run_txn("single", 2'b01, 4'd3);

        // Out-of-range and boundary addresses from requester 1.
        req_valid = 2'b10;
        req_addr  = {4'hC, 4'd0};
        run_txn("oor_c", 2'b10, 4'hC);
        req_addr  = {4'd9, 4'd0};
        run_txn("addr9", 2'b10, 4'd9);
        req_addr  = {4'hA, 4'd0};
        run_txn("depth", 2'b10, 4'hA);

        // Backpressure on requester 0; requester 1's ready must be ignored.
        req_valid = 2'b11;
        req_addr  = {4'd7, 4'd2};
        rsp_ready = 2'b10;
        #1;
        check_eq("bp.grant", 32'(req_ready), 32'b01);
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check_eq("bp.rsp_valid", 32'(rsp_valid), 32'b01);
            check_eq("bp.rsp_data", 32'(rsp_data), 32'(rom2_f(4'd2)));
            check_eq("bp.no_grant", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        check_eq("bp.released", 32'(rsp_valid), 32'd0);
        run_txn("bp_next", 2'b10, 4'd7);

        // Reset while in READ: transaction dropped.
        req_valid = 2'b01;
        req_addr  = {4'd0, 4'd4};
        @(negedge clk);
        check_eq("mid.in_read", 32'(rsp_valid), 32'd0);
        req_valid = 2'b00;
        rst       = 1'b1;
        @(negedge clk);
        check_eq("mid.rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid.rom_address", 32'(rom_address), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid.no_rsp", 32'(rsp_valid), 32'd0);
        check_eq("mid.idle_ready", 32'(req_ready), 32'd0);

        // Address sweep after reset.
        req_valid = 2'b01;
        for (int a = 0; a < 10; a++) begin
            req_addr = {4'd0, 4'(a)};
            run_txn("sweep", 2'b01, 4'(a));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
